// File: rtl/lector_contadores.sv
// Poll sweep reader for the push-counter block: requests each channel in turn,
// snapshots every returned count, accumulates the total and flags timeouts.
module lector_contadores #(
  parameter int NUM_CH  = 5,
  parameter int DATA_W  = 5,
  parameter int IDX_W   = 3,
  parameter int SUM_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              start,
  output logic              req,
  output logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [SUM_W-1:0]  total,
  input  logic [IDX_W-1:0]  snap_idx,
  output logic [DATA_W-1:0] snap_data
);

  localparam int     TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam longint MAX_SUM = longint'(NUM_CH) * ((longint'(1) << DATA_W) - 1);

  if (MAX_SUM >= (longint'(1) << SUM_W)) begin : g_sum_too_narrow
    $error("SUM_W too narrow for NUM_CH full-scale counts");
  end
  if (NUM_CH > (1 << IDX_W)) begin : g_idx_too_narrow
    $error("IDX_W too narrow to address NUM_CH channels");
  end

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_GAP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ch_q, ch_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               req_q, req_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [SUM_W-1:0]   total_q, total_d;
  logic [DATA_W-1:0]  snap_q [NUM_CH];
  logic               snap_we;
  logic [DATA_W-1:0]  snap_wdata;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      total_q <= total_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    tmo_d      = tmo_q;
    req_d      = req_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    total_d    = total_q;
    snap_we    = 1'b0;
    snap_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          ch_d    = '0;
          total_d = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_REQ: begin
        req_d   = 1'b1;
        idx_d   = ch_q;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A timed-out channel is recorded as zero and the sweep moves on.
        if (valid || tmo_q == TMO_W'(TIMEOUT - 1)) begin
          snap_we = 1'b1;
          req_d   = 1'b0;
          if (valid) begin
            snap_wdata = data;
            total_d    = total_q + SUM_W'(data);
          end else begin
            error_d = 1'b1;
          end
          if (ch_q == IDX_W'(NUM_CH - 1)) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = S_GAP;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP: state_d = S_REQ;
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
    end else if (snap_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_q == IDX_W'(i)) snap_q[i] <= snap_wdata;
      end
    end
  end

  always_comb begin
    snap_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (snap_idx == IDX_W'(i)) snap_data = snap_q[i];
    end
  end

  assign req   = req_q;
  assign idx   = idx_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;
  assign total = total_q;

endmodule
